// File: rtl/double_rate_ddr.sv
// double_rate_ddr: DDR byte capture on both clk edges, re-serialized onto dout at double rate (DOUBLE_RATE_CSN_SEL_EN: csn picks the half, else clk level does)
`timescale 1ns/100ps
module double_rate_ddr (
   input  logic       clk,
   input  logic       rstn,
   input  logic       csn,
   input  logic [7:0] din,
   input  logic       din_en,
   output logic [7:0] dout,
   output logic       dout_en
);
   logic [7:0] neg_cap_q, first_q, second_q;
   logic       neg_vld_q, dout_en_q, pair_ld_d;
   assign pair_ld_d = din_en & neg_vld_q;
   assign dout_en   = dout_en_q;
   // falling-edge capture of the older word and its valid flag
   always_ff @(negedge clk or negedge rstn)
      if (!rstn) begin
         neg_cap_q <= '0;
         neg_vld_q <= 1'b0;
      end else begin
         neg_vld_q <= din_en;
         if (din_en) neg_cap_q <= din;
      end
   // align a complete pair to the rising edge
   always_ff @(posedge clk or negedge rstn)
      if (!rstn) begin
         first_q   <= '0;
         second_q  <= '0;
         dout_en_q <= 1'b0;
      end else begin
         dout_en_q <= pair_ld_d;
         if (pair_ld_d) begin
            first_q  <= neg_cap_q;
            second_q <= din;
         end
      end
`ifdef DOUBLE_RATE_CSN_SEL_EN
   assign dout = csn ? second_q : first_q;
`else
   logic unused_csn;
   assign unused_csn = csn;
   assign dout = clk ? first_q : second_q;
`endif
endmodule

// File: tb/tb_double_rate_ddr.sv
// tb_double_rate_ddr: directed checks of pair capture, enable gaps, resets and streaming order
`timescale 1ns/100ps
module tb_double_rate_ddr;
   logic       clk, rstn, csn, din_en, dout_en, hold_csn;
   logic [7:0] din, dout, prev_f, prev_r, f, r;
   int         checks, errors;

   double_rate_ddr dut (
      .clk(clk), .rstn(rstn), .csn(csn), .din(din),
      .din_en(din_en), .dout(dout), .dout_en(dout_en)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      csn      = 1'b1;
      hold_csn = 1'b0;
   end
   always begin
      @(clk);
      #0.2;
      csn = hold_csn ? 1'b1 : ~clk;
   end

   task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   // one clk period starting 1 ns after a rising edge: drives the pair for the
   // next rising edge and checks the outputs shown during this period
   task automatic cyc(input logic en_f, input logic [7:0] d_f,
                      input logic en_r, input logic [7:0] d_r,
                      input logic exp_en, input logic [7:0] exp_first,
                      input logic [7:0] exp_second, input string tag);
      din_en = en_f;
      din    = d_f;
      #1.5;
      check({tag, " hi dout"}, dout, exp_first);
      check({tag, " hi en"}, {7'd0, dout_en}, {7'd0, exp_en});
      @(negedge clk);
      #1;
      din_en = en_r;
      din    = d_r;
      #1.5;
      check({tag, " lo dout"}, dout, exp_second);
      check({tag, " lo en"}, {7'd0, dout_en}, {7'd0, exp_en});
      @(posedge clk);
      #1;
   endtask

   initial begin
      checks = 0;
      errors = 0;
      rstn   = 1'b0;
      din_en = 1'b0;
      din    = 8'($urandom);
      #2.5;
      check("rst lo dout", dout, 8'h00);
      check("rst lo en", {7'd0, dout_en}, 8'h00);
      din = 8'($urandom);
      #5;
      check("rst hi dout", dout, 8'h00);
      check("rst hi en", {7'd0, dout_en}, 8'h00);
      din = 8'($urandom);
      @(negedge clk);
      #1;
      rstn = 1'b1;
      @(posedge clk);
      #1;
      cyc(1, 8'h11, 1, 8'h22, 0, 8'h00, 8'h00, "post_rst");
      cyc(1, 8'h33, 1, 8'h44, 1, 8'h11, 8'h22, "pair1");
      cyc(1, 8'h55, 1, 8'h66, 1, 8'h33, 8'h44, "pair2");
      cyc(0, 8'h77, 0, 8'h88, 1, 8'h55, 8'h66, "pair3");
      cyc(0, 8'h99, 0, 8'haa, 0, 8'h55, 8'h66, "drop1");
      cyc(1, 8'hbb, 1, 8'hcc, 0, 8'h55, 8'h66, "drop2");
      cyc(1, 8'hdd, 1, 8'hee, 1, 8'hbb, 8'hcc, "resume");
      cyc(1, 8'h12, 0, 8'h34, 1, 8'hdd, 8'hee, "resume2");
      cyc(0, 8'h56, 1, 8'h78, 0, 8'hdd, 8'hee, "half_r");
      cyc(1, 8'h9a, 1, 8'hbc, 0, 8'hdd, 8'hee, "half_f");
      cyc(1, 8'hde, 1, 8'hf0, 1, 8'h9a, 8'hbc, "pair4");
      prev_f = 8'hde;
      prev_r = 8'hf0;
      for (int i = 0; i < 40; i++) begin
         f = 8'($urandom);
         r = 8'($urandom);
         cyc(1, f, 1, r, 1, prev_f, prev_r, "stream");
         prev_f = f;
         prev_r = r;
      end
      din_en = 1'b1;
      din    = 8'h77;
      #2;
      rstn = 1'b0;
      #1;
      check("mrst dout", dout, 8'h00);
      check("mrst en", {7'd0, dout_en}, 8'h00);
      #2;
      rstn   = 1'b1;
      din_en = 1'b1;
      din    = 8'h88;
      #1.5;
      check("mrst rel dout", dout, 8'h00);
      check("mrst rel en", {7'd0, dout_en}, 8'h00);
      @(posedge clk);
      #1;
      cyc(1, 8'ha1, 1, 8'hb2, 0, 8'h00, 8'h00, "mrst_wait");
      cyc(1, 8'hc3, 1, 8'hd4, 1, 8'ha1, 8'hb2, "mrst_pair1");
      cyc(0, 8'h00, 0, 8'h00, 1, 8'hc3, 8'hd4, "mrst_pair2");
`ifndef DOUBLE_RATE_CSN_SEL_EN
      hold_csn = 1'b1;
      cyc(1, 8'h5a, 1, 8'ha5, 0, 8'hc3, 8'hd4, "csn_hold1");
      cyc(1, 8'h3c, 1, 8'hc3, 1, 8'h5a, 8'ha5, "csn_hold2");
      cyc(0, 8'h00, 0, 8'h00, 1, 8'h3c, 8'hc3, "csn_hold3");
      hold_csn = 1'b0;
`endif
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
